// File: rtl/md_unit.sv
// md_unit -- multiply/divide unit for the E stage of the five-stage MIPS pipeline.
//
// Owns the architectural HI/LO pair and models multi-cycle mult/div latency with
// a down-counter. The result of a mult/div is computed in the start cycle and
// parked in a shadow HI/LO pair; it becomes architecturally visible on the edge
// where the counter expires, so HI/LO show the new value from cycle N+1.
//
// Build option:
//   MD_DIVZERO_KEEP_EN  - when defined, a div/divu with a zero divisor still
//                         runs the full busy period but leaves HI/LO unchanged.
//                         When undefined, it commits HI = dividend and
//                         LO = 32'hFFFFFFFF (signed and unsigned alike).

module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDControl,
    input  logic [3:0]  E_MDDataOp,
    input  logic [31:0] E_RS,
    input  logic [31:0] E_RT,
    output logic        E_Start,
    output logic        E_Busy,
    output logic [31:0] E_MDOut
);

    // Operation codes carried down from the decoder.
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTLO  = 4'd5;
    localparam logic [3:0] MD_MTHI  = 4'd6;

    // Counter load values, narrowed once to the counter width.
    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;
    logic [31:0] shi_q,   shi_d;
    logic [31:0] slo_q,   slo_d;

    logic        is_md_op_s;
    logic        is_div_s;
    logic [63:0] result_s;

    // Full 64-bit {HI,LO} result of a mult/div. Signed divide works on
    // magnitudes so that 0x80000000 / -1 and divide-by-zero stay well defined:
    // quotient truncates toward zero, remainder takes the dividend's sign.
    function automatic logic [63:0] md_compute(
        input logic [3:0]  code,
        input logic [31:0] rs,
        input logic [31:0] rt,
        input logic [31:0] hi_cur,
        input logic [31:0] lo_cur
    );
        logic [63:0] res;
        logic [31:0] abs_rs;
        logic [31:0] abs_rt;
        logic [31:0] q_mag;
        logic [31:0] r_mag;
        logic [31:0] quo;
        logic [31:0] rem;
        res    = {hi_cur, lo_cur};
        abs_rs = rs[31] ? (32'd0 - rs) : rs;
        abs_rt = rt[31] ? (32'd0 - rt) : rt;
        q_mag  = 32'd0;
        r_mag  = 32'd0;
        quo    = 32'd0;
        rem    = 32'd0;
        case (code)
            MD_MULT: begin
                res = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
            end
            MD_MULTU: begin
                res = {32'd0, rs} * {32'd0, rt};
            end
            MD_DIV: begin
                if (rt == 32'd0) begin
`ifdef MD_DIVZERO_KEEP_EN
                    res = {hi_cur, lo_cur};
`else
                    res = {rs, 32'hFFFF_FFFF};
`endif
                end else begin
                    q_mag = abs_rs / abs_rt;
                    r_mag = abs_rs % abs_rt;
                    quo   = (rs[31] ^ rt[31]) ? (32'd0 - q_mag) : q_mag;
                    rem   = rs[31] ? (32'd0 - r_mag) : r_mag;
                    res   = {rem, quo};
                end
            end
            MD_DIVU: begin
                if (rt == 32'd0) begin
`ifdef MD_DIVZERO_KEEP_EN
                    res = {hi_cur, lo_cur};
`else
                    res = {rs, 32'hFFFF_FFFF};
`endif
                end else begin
                    res = {rs % rt, rs / rt};
                end
            end
            default: begin
                res = {hi_cur, lo_cur};
            end
        endcase
        return res;
    endfunction

    // A start is only legal from idle; codes 1-4 while busy are dropped.
    assign is_md_op_s = (E_MDControl >= MD_MULT) && (E_MDControl <= MD_DIVU);
    assign is_div_s   = (E_MDControl == MD_DIV) || (E_MDControl == MD_DIVU);
    assign result_s   = md_compute(E_MDControl, E_RS, E_RT, hi_q, lo_q);

    // State register plus HI/LO, shadow and counter flops; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            shi_q   <= 32'd0;
            slo_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            shi_q   <= shi_d;
            slo_q   <= slo_d;
        end
    end

    // Next-state: start/mtxx handling in idle, countdown and commit in run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        shi_d   = shi_q;
        slo_d   = slo_q;
        case (state_q)
            ST_IDLE: begin
                if (is_md_op_s) begin
                    shi_d   = result_s[63:32];
                    slo_d   = result_s[31:0];
                    cnt_d   = is_div_s ? DIV_LD : MULT_LD;
                    state_d = ST_RUN;
                end else if (E_MDControl == MD_MTLO) begin
                    lo_d = E_RS;
                end else if (E_MDControl == MD_MTHI) begin
                    hi_d = E_RS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Everything arriving while busy is ignored; only the countdown moves.
                if (cnt_q <= 4'd1) begin
                    hi_d    = shi_q;
                    lo_d    = slo_q;
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: start strobe for the hazard unit, busy from the state flop, HI/LO read mux.
    always_comb begin
        E_Start = 1'b0;
        E_Busy  = 1'b0;
        E_MDOut = lo_q;
        case (state_q)
            ST_IDLE: begin
                E_Start = is_md_op_s;
                E_Busy  = 1'b0;
            end
            ST_RUN: begin
                E_Start = 1'b0;
                E_Busy  = 1'b1;
            end
            default: begin
                E_Start = 1'b0;
                E_Busy  = 1'b0;
            end
        endcase
        if (E_MDDataOp == 4'd1) begin
            E_MDOut = hi_q;
        end else begin
            E_MDOut = lo_q;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit (default MULT_CYCLES=5, DIV_CYCLES=10).
// Expected HI/LO results are pushed to a scoreboard queue when an operation is
// issued and popped/compared once E_Busy falls.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  ctl;
    logic [3:0]  dop;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        start;
    logic        busy;
    logic [31:0] mdout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t sb[$];

    md_unit dut (
        .clk         (clk),
        .reset       (reset),
        .E_MDControl (ctl),
        .E_MDDataOp  (dop),
        .E_RS        (rs),
        .E_RT        (rt),
        .E_Start     (start),
        .E_Busy      (busy),
        .E_MDOut     (mdout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive an MD op and record the result it must eventually commit.
    task automatic issue(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input string name);
        exp_t e;
        ctl = code;
        rs  = a;
        rt  = b;
        e.hi = ehi;
        e.lo = elo;
        e.name = name;
        sb.push_back(e);
        #1;
    endtask

    // Count remaining busy cycles, bounded so a stuck DUT cannot hang the run.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        dop = 4'd1;
        #1;
        h = mdout;
        dop = 4'd0;
        #1;
        l = mdout;
    endtask

    task automatic test_reset();
        logic [31:0] h, l;
        reset = 1'b0;
        ctl = 4'd0; dop = 4'd0; rs = 32'd0; rt = 32'd0;
        repeat (2) tick();
        reset = 1'b1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", start); end
        read_hilo(h, l);
        n_checks++; if (h !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", h); end
        n_checks++; if (l !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", l); end
        ctl = 4'd8;
        #1;
        n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL code8_start: got %b expected 0", start); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL code8_busy: got %b expected 0", busy); end
        ctl = 4'd0;
    endtask

    task automatic test_mult();
        int n;
        exp_t e;
        logic [31:0] h, l;
        issue(4'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult");
        n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL mult_start: got %b expected 1", start); end
        tick();
        ctl = 4'd0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy_c1: got %b expected 1", busy); end
        wait_idle(n);
        n_checks++; if (n !== 5) begin n_fail++; $display("FAIL mult_busy_len: got %0d expected 5", n); end
        e = sb.pop_front();
        read_hilo(h, l);
        n_checks++; if (h !== e.hi) begin n_fail++; $display("FAIL %s_hi: got %h expected %h", e.name, h, e.hi); end
        n_checks++; if (l !== e.lo) begin n_fail++; $display("FAIL %s_lo: got %h expected %h", e.name, l, e.lo); end
    endtask

    task automatic test_multu();
        int n;
        exp_t e;
        logic [31:0] h, l;
        issue(4'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
        tick();
        ctl = 4'd7;
        dop = 4'd0;
        #1;
        n_checks++; if (mdout !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mflo_busy: got %h expected fffffffe", mdout); end
        dop = 4'd1;
        #1;
        n_checks++; if (mdout !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mfhi_busy: got %h expected ffffffff", mdout); end
        dop = 4'd0;
        ctl = 4'd0;
        wait_idle(n);
        n_checks++; if (n !== 5) begin n_fail++; $display("FAIL multu_busy_len: got %0d expected 5", n); end
        e = sb.pop_front();
        read_hilo(h, l);
        n_checks++; if (h !== e.hi) begin n_fail++; $display("FAIL %s_hi: got %h expected %h", e.name, h, e.hi); end
        n_checks++; if (l !== e.lo) begin n_fail++; $display("FAIL %s_lo: got %h expected %h", e.name, l, e.lo); end
    endtask

    task automatic test_div();
        logic [3:0]  codes [4] = '{4'd3, 4'd4, 4'd3, 4'd3};
        logic [31:0] a     [4] = '{32'hFFFF_FFF9, 32'd7, 32'd7, 32'h8000_0000};
        logic [31:0] b     [4] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] ehi   [4] = '{32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0};
        logic [31:0] elo   [4] = '{32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFD, 32'h8000_0000};
        int n;
        exp_t e;
        logic [31:0] h, l;
        for (int i = 0; i < 4; i++) begin
            issue(codes[i], a[i], b[i], ehi[i], elo[i], $sformatf("div%0d", i));
            n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL div%0d_start: got %b expected 1", i, start); end
            tick();
            ctl = 4'd0;
            wait_idle(n);
            n_checks++; if (n !== 10) begin n_fail++; $display("FAIL div%0d_busy_len: got %0d expected 10", i, n); end
            e = sb.pop_front();
            read_hilo(h, l);
            n_checks++; if (h !== e.hi) begin n_fail++; $display("FAIL %s_hi: got %h expected %h", e.name, h, e.hi); end
            n_checks++; if (l !== e.lo) begin n_fail++; $display("FAIL %s_lo: got %h expected %h", e.name, l, e.lo); end
        end
    endtask

    task automatic test_mtxx();
        int n;
        exp_t e;
        logic [31:0] h, l;
        ctl = 4'd6; rs = 32'h0000_1234;
        tick();
        ctl = 4'd5; rs = 32'h0000_5678;
        tick();
        ctl = 4'd0;
        read_hilo(h, l);
        n_checks++; if (h !== 32'h0000_1234) begin n_fail++; $display("FAIL mthi_idle: got %h expected 00001234", h); end
        n_checks++; if (l !== 32'h0000_5678) begin n_fail++; $display("FAIL mtlo_idle: got %h expected 00005678", l); end
        issue(4'd1, 32'd3, 32'd4, 32'd0, 32'd12, "mult_vs_mthi");
        tick();
        ctl = 4'd6; rs = 32'h0000_AAAA;
        tick();
        ctl = 4'd1; rs = 32'd9; rt = 32'd9;
        #1;
        n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL start_while_busy: got %b expected 0", start); end
        tick();
        ctl = 4'd0;
        wait_idle(n);
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL busy_remaining: got %0d expected 3", n); end
        e = sb.pop_front();
        read_hilo(h, l);
        n_checks++; if (h !== e.hi) begin n_fail++; $display("FAIL %s_hi: got %h expected %h", e.name, h, e.hi); end
        n_checks++; if (l !== e.lo) begin n_fail++; $display("FAIL %s_lo: got %h expected %h", e.name, l, e.lo); end
    endtask

    task automatic test_back_to_back();
        int n;
        exp_t e;
        logic [31:0] h, l;
        issue(4'd2, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, "b2b_multu");
        tick();
        ctl = 4'd0;
        wait_idle(n);
        e = sb.pop_front();
        read_hilo(h, l);
        n_checks++; if (h !== e.hi) begin n_fail++; $display("FAIL %s_hi: got %h expected %h", e.name, h, e.hi); end
        n_checks++; if (l !== e.lo) begin n_fail++; $display("FAIL %s_lo: got %h expected %h", e.name, l, e.lo); end
        issue(4'd4, 32'd100, 32'd7, 32'd2, 32'd14, "b2b_divu");
        n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL b2b_start: got %b expected 1", start); end
        tick();
        ctl = 4'd0;
        wait_idle(n);
        n_checks++; if (n !== 10) begin n_fail++; $display("FAIL b2b_busy_len: got %0d expected 10", n); end
        e = sb.pop_front();
        read_hilo(h, l);
        n_checks++; if (h !== e.hi) begin n_fail++; $display("FAIL %s_hi: got %h expected %h", e.name, h, e.hi); end
        n_checks++; if (l !== e.lo) begin n_fail++; $display("FAIL %s_lo: got %h expected %h", e.name, l, e.lo); end
    endtask

    task automatic test_abort_and_divzero();
        int n;
        exp_t e;
        logic [31:0] h, l;
        // Aborted op: nothing pushed, it must never commit.
        ctl = 4'd3; rs = 32'd100; rt = 32'd7;
        tick();
        ctl = 4'd0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        read_hilo(h, l);
        n_checks++; if (h !== 32'd0) begin n_fail++; $display("FAIL abort_hi: got %h expected 0", h); end
        n_checks++; if (l !== 32'd0) begin n_fail++; $display("FAIL abort_lo: got %h expected 0", l); end
        repeat (10) tick();
        read_hilo(h, l);
        n_checks++; if (l !== 32'd0) begin n_fail++; $display("FAIL abort_late_lo: got %h expected 0", l); end
`ifdef MD_DIVZERO_KEEP_EN
        issue(4'd4, 32'h0000_0010, 32'd0, 32'd0, 32'd0, "divu_zero");
`else
        issue(4'd4, 32'h0000_0010, 32'd0, 32'h0000_0010, 32'hFFFF_FFFF, "divu_zero");
`endif
        tick();
        ctl = 4'd0;
        wait_idle(n);
        n_checks++; if (n !== 10) begin n_fail++; $display("FAIL divzero_busy_len: got %0d expected 10", n); end
        e = sb.pop_front();
        read_hilo(h, l);
        n_checks++; if (h !== e.hi) begin n_fail++; $display("FAIL %s_hi: got %h expected %h", e.name, h, e.hi); end
        n_checks++; if (l !== e.lo) begin n_fail++; $display("FAIL %s_lo: got %h expected %h", e.name, l, e.lo); end
`ifdef MD_DIVZERO_KEEP_EN
        issue(4'd3, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'd0, "div_zero");
`else
        issue(4'd3, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, "div_zero");
`endif
        tick();
        ctl = 4'd0;
        wait_idle(n);
        e = sb.pop_front();
        read_hilo(h, l);
        n_checks++; if (h !== e.hi) begin n_fail++; $display("FAIL %s_hi: got %h expected %h", e.name, h, e.hi); end
        n_checks++; if (l !== e.lo) begin n_fail++; $display("FAIL %s_lo: got %h expected %h", e.name, l, e.lo); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_mtxx();
        test_back_to_back();
        test_abort_and_divzero();
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
